// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 arbitrated multiplexer.
// Select-width helper keeps a 1-bit index for the 2-channel case.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_safe(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches ptr+1, ptr+2, ... modulo N; first requester wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (en) begin
      // Walk from farthest to nearest so the nearest match lands last.
      for (int k = N; k >= 1; k--) begin
        c = (int'(ptr) + k) % N;
        if (req[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_1_arb.sv
// N:1 valid/ready multiplexer with fixed or round-robin select and a
// registered output stage. Define MUX_LOCK_EN to add the burst lock input.
module mux_n_1_arb
  import mux_pkg::*;
#(
  parameter  int W  = 4,
  parameter  int N  = 4,
  localparam int SW = clog2_safe(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_src
`ifdef MUX_LOCK_EN
  ,
  input  logic           lock
`endif
);

  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          lock_act;
  logic          arb_en;
  logic          arb_vld;
  logic [SW-1:0] arb_idx;
  logic          fx_vld;
  logic          lk_vld;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          load;
  logic          xfer;

`ifdef MUX_LOCK_EN
  assign lock_act = (mode == MODE_RR) && lock;
`else
  assign lock_act = 1'b0;
`endif

  assign arb_en = (mode == MODE_RR) && !lock_act;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  // Index loops keep out-of-range sel (non-power-of-2 N) grant-free.
  always_comb begin
    fx_vld = 1'b0;
    lk_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i))   fx_vld = in_valid[i];
      if (ptr_q == SW'(i)) lk_vld = in_valid[i];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    unique case (1'b1)
      (mode == MODE_FIXED): begin
        gnt_vld = fx_vld;
        gnt_idx = sel;
      end
      lock_act: begin
        gnt_vld = lk_vld;
        gnt_idx = ptr_q;
      end
      default: begin
        gnt_vld = arb_vld;
        gnt_idx = arb_idx;
      end
    endcase
  end

  assign load = !valid_q || out_ready;
  assign xfer = reset_n && load && gnt_vld;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = gnt_data;
      src_d   = gnt_idx;
      valid_d = 1'b1;
      if (arb_en) ptr_d = gnt_idx;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      ptr_q   <= SW'(N-1);
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Bench for mux_n_1_arb: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_mux_n_1_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_src;
  logic           lock_s;
  logic           lock_eff;
  logic [W-1:0]   d [N];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: output register contents and last round-robin winner.
  bit       m_v;
  logic [W-1:0] m_d;
  int       m_s;
  int       m_ptr;

  always #5 clk = ~clk;

  assign in_data = {d[3], d[2], d[1], d[0]};

`ifdef MUX_LOCK_EN
  assign lock_eff = lock_s;
`else
  assign lock_eff = 1'b0;
`endif

  mux_n_1_arb #(
    .W (W),
    .N (N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef MUX_LOCK_EN
    ,
    .lock      (lock_s)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) g = int'(sel);
    end else if (lock_eff) begin
      if (in_valid[m_ptr]) g = m_ptr;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    return g;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = model_grant();
    if (reset_n && (!m_v || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    automatic int g = model_grant();
    automatic bit ld = !m_v || out_ready;
    if (!reset_n) begin
      m_v   <= 1'b0;
      m_d   <= '0;
      m_s   <= 0;
      m_ptr <= N - 1;
    end else if (ld && g >= 0) begin
      m_v <= 1'b1;
      m_d <= d[g];
      m_s <= g;
      if (mode && !lock_eff) m_ptr <= g;
    end else if (ld) begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_v));
      chk("out_data",  32'(out_data),  32'(m_d));
      chk("out_src",   32'(out_src),   32'(m_s));
      chk("in_ready",  32'(in_ready),  32'(exp_ready()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    lock_s    = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);

    cyc();
    chk_en = 1'b1;
    cyc();
    mid();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_ready", 32'(in_ready),  0);

    reset_n = 1'b1;
    #1;
    chk("rel_ready", 32'(in_ready), 32'h1);
    cyc();
    mid();
    chk("first_valid", 32'(out_valid), 1);
    chk("first_data",  32'(out_data),  32'h10);

    sel      = 2'd2;
    d[2]     = 8'hA5;
    in_valid = 4'b0100;
    #1;
    chk("fx_ready", 32'(in_ready), 32'b0100);
    cyc();
    mid();
    chk("fx_data",  32'(out_data),  32'hA5);
    chk("fx_src",   32'(out_src),   2);
    chk("fx_valid", 32'(out_valid), 1);
    sel = 2'd3;
    #1;
    chk("fx_nogrant", 32'(in_ready), 0);
    cyc();
    mid();
    chk("fx_drop", 32'(out_valid), 0);
    chk("fx_hold", 32'(out_data),  32'hA5);

    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);
    for (int k = 0; k < 6; k++) begin
      cyc();
      mid();
      chk("rr_src",  32'(out_src),  32'(k % 4));
      chk("rr_data", 32'(out_data), 32'(8'h10 + k % 4));
    end

    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      chk("bp_data",  32'(out_data),  32'h11);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready),  0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'b0100);
    cyc();
    mid();
    chk("bp_next_src",  32'(out_src),  2);
    chk("bp_next_data", 32'(out_data), 32'h12);

    reset_n = 1'b0;
    cyc();
    reset_n  = 1'b1;
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      cyc();
      mid();
      chk("sparse_src", 32'(out_src), (k % 2 == 0) ? 0 : 3);
    end
    reset_n = 1'b0;
    cyc();
    mid();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready),  0);
    reset_n = 1'b1;
    cyc();
    mid();
    chk("restart_src",   32'(out_src),   0);
    chk("restart_valid", 32'(out_valid), 1);

`ifdef MUX_LOCK_EN
    reset_n = 1'b0;
    cyc();
    reset_n  = 1'b1;
    in_valid = 4'b1111;
    cyc();
    cyc();
    mid();
    chk("lk_pre", 32'(out_src), 1);
    lock_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      chk("lk_src", 32'(out_src), 1);
    end
    lock_s = 1'b0;
    cyc();
    mid();
    chk("lk_after", 32'(out_src), 2);
`endif

    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset_n   = ($urandom % 60) != 0;
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) d[i] = 8'($urandom);
`ifdef MUX_LOCK_EN
      lock_s = ($urandom % 3) == 0;
`endif
    end
    cyc();
    mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_1_arb.md
Name: mux_n_1_arb

Overview:
- Parametrised N-to-1 datapath multiplexer, successor to the plain 2:1 combinational select.
- Adds per-channel valid/ready handshakes and a registered output stage.
- Selects in one of two modes: fixed (external select) or round-robin arbitration.
- Shares one downstream consumer (e.g. memory/register-file write port) between N producers in the CPU datapath.

Parameters:
- W, 4, data width per channel.
- N, 4, channel count (N >= 2).
- SW, $clog2(N), select/source index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept (combinational).
- sel  input  SW  channel index, used in fixed mode.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream accept.
- out_src  output  SW  registered index of channel that supplied out_data.

Behaviour:
- Reset:
  - Sampled only on a clk edge while reset_n = 0.
  - Drives out_data = 0, out_valid = 0, out_src = 0, rr_ptr = N-1 (first round-robin search starts at channel 0).
  - in_ready is all-zero during reset.
  - Reset mid-transfer drops the held beat; no transfer is reported.
- Load condition: load = !out_valid || out_ready.
  - The output register accepts a new beat when empty or when being drained the same cycle.
  - Sustains 1 beat/cycle.
- Grant, fixed mode:
  - grant = sel when in_valid[sel] = 1; otherwise no grant.
  - sel >= N (non-power-of-2 N) gives no grant.
- Grant, round-robin mode:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo N (wraps N-1 -> 0).
  - The first with in_valid = 1 wins.
  - rr_ptr updates to the winner only on an accepted beat.
- Accept: in_ready[i] = load && granted && (i == grant); all other bits 0. Exactly one in_ready bit high at most.
- Transfer on an input channel occurs when in_valid[i] && in_ready[i].
  - Next cycle: out_data = in_data[grant], out_src = grant, out_valid = 1.
- No grant while load = 1: out_valid -> 0 next cycle if it was drained; out_data and out_src hold their last values.
- Latency: 1 cycle input-to-output. No combinational path from in_data to out_data.
- Backpressure: out_valid && !out_ready holds out_data, out_src and out_valid stable, and all in_ready = 0.
- Mode or sel change takes effect on the same-cycle grant. rr_ptr is kept across mode switches and is not updated by fixed-mode grants.
- Input protocol: producers must hold in_valid/in_data until accepted. The block does not check this.

Optional Feature:
- Macro: MUX_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock = 1 in round-robin mode, the grant is forced to rr_ptr (the last winner) if in_valid[rr_ptr] = 1; otherwise no grant. This supports multi-beat bursts.
  - rr_ptr is frozen.
  - lock has no effect in fixed mode.
- Undefined: no lock port; arbitration always advances as above.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants.
  - Function clog2_safe, returning 1 for N <= 2.
- Sub-module rr_arbiter (N, SW): inputs req[N], ptr[SW], en; outputs gnt_vld, gnt_idx. Purely combinational priority rotate.
- Datapath select and output register stay in mux_n_1_arb.

Test Plan (N=4, W=8):
- Reset: hold reset_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0x00, in_ready = 4'b0000. Release -> first beat appears 1 cycle later.
- Fixed mode, continuous accept: sel = 2, in_data ch2 = 0xA5, in_valid = 4'b0100, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 0xA5, out_src = 2, out_valid = 1. sel = 3 with in_valid[3] = 0 -> in_ready = 0, out_valid drops.
- Round-robin fairness with wrap: mode = 1, in_valid = 4'b1111, data ch i = 0x10+i, out_ready = 1 -> out_src sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10.
- Backpressure: out_valid = 1 with 0x11 held, out_ready = 0 for 3 cycles -> out_data stays 0x11, in_ready = 0000. Raise out_ready -> next beat (src 2) loads the same cycle, no bubble.
- Sparse round-robin: in_valid = 4'b1001, rr_ptr = 0 -> grants 3 then 0 then 3. Reset asserted mid-stream -> out_valid = 0 next cycle, sequence restarts at 0.
- MUX_LOCK_EN build: after ch1 wins, hold lock = 1 with in_valid = 4'b1111 for 3 beats -> out_src = 1,1,1. Drop lock -> next grant is 2.
